// File: rtl/adsr_env.sv
// ADSR envelope generator: turns the note gate into a 16-bit gain ramp
// (attack/decay/sustain/release) that is updated on a prescaled tick.
module adsr_env #(
  parameter int unsigned CLKSPEED = 50_000_000,
  parameter int unsigned TICK_HZ  = 10_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gate,
  input  logic [15:0] attack_step,
  input  logic [15:0] decay_step,
  input  logic [15:0] sustain_level,
  input  logic [15:0] release_step,
  output logic [15:0] amp_out,
  output logic [2:0]  stage,
  output logic        busy
);

  localparam int unsigned DIV = CLKSPEED / TICK_HZ;
  localparam int unsigned CW  = $clog2(DIV);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_t;

  stage_t        state_q, state_d;
  logic [15:0]   level_q, level_d;
  logic          gate_q;
  logic [CW-1:0] presc_q;
  logic          tick, rise, fall;
  logic [16:0]   att_sum, dec_diff, rel_diff;

  assign tick = (presc_q == CW'(DIV - 1));
  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  // State, level, gate history and free-running prescaler registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= gate;
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  // Next stage and level: gate edges take precedence and freeze the level
  // for that cycle; otherwise the per-stage ramp runs on tick.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    att_sum  = {1'b0, level_q} + {1'b0, attack_step};
    dec_diff = {1'b0, level_q} - {1'b0, decay_step};
    rel_diff = {1'b0, level_q} - {1'b0, release_step};
    if (rise) begin
      state_d = ATTACK;
    end else if (fall && (state_q == ATTACK || state_q == DECAY ||
                          state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else begin
      case (state_q)
        IDLE:    level_d = '0;
        SUSTAIN: level_d = sustain_level;
        ATTACK: begin
          if (tick) begin
            if (attack_step == '0 || att_sum[16]) level_d = '1;
            else                                  level_d = att_sum[15:0];
            if (level_d == '1) state_d = DECAY;
          end
        end
        DECAY: begin
          if (tick) begin
            if (decay_step == '0 || dec_diff[16] || dec_diff[15:0] < sustain_level)
              level_d = sustain_level;
            else
              level_d = dec_diff[15:0];
            if (level_d == sustain_level) state_d = SUSTAIN;
          end
        end
        RELEASE: begin
          if (tick) begin
            if (release_step == '0 || rel_diff[16]) level_d = '0;
            else                                    level_d = rel_diff[15:0];
            if (level_d == '0) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  assign amp_out = level_q;
  assign stage   = state_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// Bench for adsr_env: an integer-arithmetic envelope model checked against
// the DUT every cycle, plus directed scenarios with literal expectations.
module tb_adsr_env;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gate;
  logic [15:0] attack_step, decay_step, sustain_level, release_step;
  logic [15:0] amp_out;
  logic [2:0]  stage;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model state: stage numbers 0..4 as listed for the stage output
  int m_level = 0;
  int m_stage = 0;
  int m_cnt   = 0;
  bit m_gq    = 1'b0;
  bit m_ticked = 1'b0;

  adsr_env #(.CLKSPEED(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .amp_out(amp_out), .stage(stage), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Envelope model: evaluates the envelope rules with plain integers.
  always @(posedge clk) begin : model
    int  lv, st, sus;
    bit  tk, rs, fl;
    if (!rst_n) begin
      m_level  <= 0;
      m_stage  <= 0;
      m_cnt    <= 0;
      m_gq     <= 1'b0;
      m_ticked <= 1'b0;
    end else begin
      lv  = m_level;
      st  = m_stage;
      sus = int'(sustain_level);
      tk  = (m_cnt == DIV - 1);
      rs  = gate && !m_gq;
      fl  = !gate && m_gq;
      if (rs) st = 1;
      else if (fl && st >= 1 && st <= 3) st = 4;
      else if (st == 0) lv = 0;
      else if (st == 3) lv = sus;
      else if (tk) begin
        if (st == 1) begin
          lv = (attack_step == 0) ? 65535 : imin(lv + int'(attack_step), 65535);
          if (lv == 65535) st = 2;
        end else if (st == 2) begin
          lv = (decay_step == 0) ? sus : imax(lv - int'(decay_step), sus);
          if (lv == sus) st = 3;
        end else begin
          lv = (release_step == 0) ? 0 : imax(lv - int'(release_step), 0);
          if (lv == 0) st = 0;
        end
      end
      m_level  <= lv;
      m_stage  <= st;
      m_cnt    <= tk ? 0 : m_cnt + 1;
      m_gq     <= gate;
      m_ticked <= tk;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_amp",   int'(amp_out), m_level);
      check("model_stage", int'(stage),   m_stage);
      check("model_busy",  int'(busy),    (m_stage != 0) ? 1 : 0);
    end
  end

  task automatic tick_wait();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ticked && n < 3 * DIV);
    if (!m_ticked) check("tick_timeout", 0, 1);
  endtask

  task automatic idle_wait();
    int n = 0;
    while (stage != 3'd0 && n < 40 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(stage), 0);
  endtask

  task automatic set_steps(input int a, input int d, input int s, input int r);
    attack_step   = 16'(a);
    decay_step    = 16'(d);
    sustain_level = 16'(s);
    release_step  = 16'(r);
  endtask

  initial begin
    rst_n = 1'b0;
    gate  = 1'b1;
    set_steps('h4000, 'h1000, 'h8000, 'h2000);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // 1: reset with gate held high
    check("rst_amp",   int'(amp_out), 0);
    check("rst_stage", int'(stage),   0);
    check("rst_busy",  int'(busy),    0);
    rst_n = 1'b1;
    gate  = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    check("post_rst_idle", int'(stage), 0);

    // 2: full cycle
    gate = 1'b1;
    @(negedge clk);
    check("att_enter", int'(stage), 1);
    tick_wait(); check("att1", int'(amp_out), 'h4000);
    tick_wait(); check("att2", int'(amp_out), 'h8000);
    tick_wait(); check("att3", int'(amp_out), 'hC000);
    tick_wait(); check("att4", int'(amp_out), 'hFFFF);
    check("to_decay", int'(stage), 2);
    for (int k = 1; k <= 8; k++) begin
      tick_wait();
      check("decay", int'(amp_out), imax('hFFFF - k * 'h1000, 'h8000));
    end
    check("to_sustain", int'(stage), 3);
    repeat (15) @(negedge clk);
    gate = 1'b0;
    @(negedge clk);
    check("rel_enter", int'(stage), 4);
    tick_wait(); check("rel1", int'(amp_out), 'h6000);
    tick_wait(); check("rel2", int'(amp_out), 'h4000);
    tick_wait(); check("rel3", int'(amp_out), 'h2000);
    tick_wait(); check("rel4", int'(amp_out), 'h0000);
    check("rel_idle", int'(stage), 0);

    // 3: saturation on attack and release
    set_steps('hF000, 'h0000, 'h8000, 'hF000);
    gate = 1'b1;
    tick_wait(); check("sat_att1", int'(amp_out), 'hF000);
    tick_wait(); check("sat_att2", int'(amp_out), 'hFFFF);
    tick_wait(); check("sat_dec",  int'(amp_out), 'h8000);
    gate = 1'b0;
    tick_wait(); check("sat_rel", int'(amp_out), 'h0000);
    check("sat_idle", int'(stage), 0);

    // 4: retrigger during release
    set_steps('h4000, 'h0000, 'h8000, 'h2000);
    gate = 1'b1;
    repeat (5) tick_wait();
    check("rt_sus", int'(amp_out), 'h8000);
    gate = 1'b0;
    tick_wait(); tick_wait();
    check("rt_rel", int'(amp_out), 'h4000);
    repeat (3) @(negedge clk);
    gate = 1'b1;
    @(negedge clk);
    check("rt_stage", int'(stage), 1);
    check("rt_hold",  int'(amp_out), 'h4000);
    tick_wait(); check("rt_att", int'(amp_out), 'h8000);
    gate = 1'b0;
    idle_wait();

    // 5: instant steps, then sustain at full scale
    set_steps(0, 0, 'h1234, 0);
    gate = 1'b1;
    tick_wait(); check("inst_att", int'(amp_out), 'hFFFF);
    tick_wait(); check("inst_dec", int'(amp_out), 'h1234);
    check("inst_sus", int'(stage), 3);
    gate = 1'b0;
    tick_wait(); check("inst_rel", int'(amp_out), 0);
    check("inst_idle", int'(stage), 0);
    sustain_level = 16'hFFFF;
    gate = 1'b1;
    tick_wait(); check("full_att", int'(stage), 2);
    tick_wait(); check("full_sus", int'(stage), 3);
    check("full_amp", int'(amp_out), 'hFFFF);
    gate = 1'b0;
    idle_wait();

    // 6: rise on a tick cycle, then live sustain change
    set_steps('h4000, 'h0000, 'h8000, 'h2000);
    gate = 1'b1;
    repeat (5) tick_wait();
    gate = 1'b0;
    tick_wait(); check("col_rel", int'(amp_out), 'h6000);
    begin
      int n = 0;
      while (m_cnt != DIV - 1 && n < 3 * DIV) begin
        @(negedge clk);
        n++;
      end
    end
    gate = 1'b1;
    @(negedge clk);
    check("col_stage", int'(stage), 1);
    check("col_hold",  int'(amp_out), 'h6000);
    tick_wait(); check("col_att1", int'(amp_out), 'hA000);
    tick_wait(); check("col_att2", int'(amp_out), 'hE000);
    tick_wait(); check("col_att3", int'(amp_out), 'hFFFF);
    tick_wait(); check("col_sus",  int'(amp_out), 'h8000);
    repeat (3) @(negedge clk);
    sustain_level = 16'h9000;
    @(negedge clk);
    check("live_sus", int'(amp_out), 'h9000);
    gate = 1'b0;
    idle_wait();
    check("end_amp", int'(amp_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
